// File: rtl/pipe_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_control_unit                                            |
// | Description : ID-stage decoder feeding a registered ID/EX control word,    |
// |               with load-use interlock, branch/jump squash, MULT/DIV busy   |
// |               tracking and illegal-opcode flagging.                        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module pipe_control_unit #(
    parameter int unsigned MULDIV_CYCLES  = 4,
    parameter int unsigned LOAD_USE_STALL = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] Instruction,
    input  logic        InstrValid,
    input  logic        BranchTaken,
    output logic        Stall,
    output logic        IllegalInstr,
    output logic        ExRegDst,
    output logic        ExRegWriteEnable,
    output logic        ExALUSrc,
    output logic        ExMemoryRE,
    output logic        ExMemoryWE,
    output logic        ExMemoryToReg,
    output logic        ExJump,
    output logic        ExPCFromReg,
    output logic        ExWriteRegFromPC,
    output logic        ExForceWriteToR31,
    output logic [5:0]  ExALUFunction,
    output logic [1:0]  ExSizeOut,
    output logic        ExLoadUnsigned,
    output logic [4:0]  ExWriteReg,
    output logic        MulDivBusy
);

    typedef struct packed {
        logic       regDst;
        logic       regWriteEnable;
        logic       aluSrc;
        logic       memoryRE;
        logic       memoryWE;
        logic       memoryToReg;
        logic       jump;
        logic       pcFromReg;
        logic       writeRegFromPC;
        logic       forceWriteToR31;
        logic [5:0] aluFunction;
        logic [1:0] sizeOut;
        logic       loadUnsigned;
        logic [4:0] writeReg;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t      c_NOOP        = '{sizeOut: 2'b11, default: '0};
    localparam logic [5:0] c_FN_JR       = 6'b001000;
    localparam logic [5:0] c_FN_JALR     = 6'b001001;
    localparam logic [5:0] c_ALU_JUMP    = 6'b111010;
    localparam logic [5:0] c_ALU_ADD     = 6'b100000;
    localparam logic [3:0] c_MULDIV_LOAD = 4'(MULDIV_CYCLES - 1);

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic       w_unusedShamt;

    ctrl_t      w_dec;
    logic       w_readsRs;
    logic       w_readsRt;
    logic       w_isMulDiv;
    logic       w_isHiLoRead;
    logic       w_flush;
    logic       w_loadUse;
    logic       w_mulDivStall;
    logic       w_bubble;

    ctrl_t      r_ex;
    logic [3:0] r_mulDivCount;
    logic       r_mulDivBusy;

    assign w_op          = Instruction[31:26];
    assign w_rs          = Instruction[25:21];
    assign w_rt          = Instruction[20:16];
    assign w_rd          = Instruction[15:11];
    assign w_funct       = Instruction[5:0];
    assign w_unusedShamt = ^Instruction[10:6];

    always_comb begin
        w_dec        = c_NOOP;
        w_readsRs    = 1'b0;
        w_readsRt    = 1'b0;
        w_isMulDiv   = 1'b0;
        w_isHiLoRead = 1'b0;
        if (InstrValid && (Instruction != 32'd0)) begin
            casez (w_op)
                6'b000000: begin
                    case (w_funct)
                        c_FN_JR, c_FN_JALR: begin
                            w_dec.jump        = 1'b1;
                            w_dec.pcFromReg   = 1'b1;
                            w_dec.aluFunction = c_ALU_JUMP;
                            w_readsRs         = 1'b1;
                            w_readsRt         = 1'b1;
                            if (w_funct == c_FN_JALR) begin
                                w_dec.regWriteEnable = 1'b1;
                                w_dec.regDst         = 1'b1;
                                w_dec.writeRegFromPC = 1'b1;
                            end
                        end
                        6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
                        6'b010000, 6'b010001, 6'b010010, 6'b010011,
                        6'b011000, 6'b011001, 6'b011010, 6'b011011,
                        6'b100000, 6'b100001, 6'b100010, 6'b100011,
                        6'b100100, 6'b100101, 6'b100110, 6'b100111,
                        6'b101010, 6'b101011: begin
                            w_dec.regDst         = 1'b1;
                            w_dec.regWriteEnable = 1'b1;
                            w_dec.aluFunction    = w_funct;
                            w_readsRt            = 1'b1;
                            // Constant shifts and MFHI/MFLO ignore the rs field.
                            w_readsRs    = !(w_funct inside {6'b000000, 6'b000010, 6'b000011,
                                                             6'b010000, 6'b010010});
                            w_isMulDiv   = (w_funct[5:2] == 4'b0110);
                            w_isHiLoRead = (w_funct == 6'b010000) || (w_funct == 6'b010010);
                        end
                        default: w_dec.illegal = 1'b1;
                    endcase
                end
                6'b000001: begin
                    if (w_rt[4:1] == 4'd0) begin
                        w_dec.aluFunction = {5'b11100, w_rt[0]};
                        w_readsRs         = 1'b1;
                    end else begin
                        w_dec.illegal = 1'b1;
                    end
                end
                6'b000010, 6'b000011: begin
                    w_dec.jump        = 1'b1;
                    w_dec.aluFunction = c_ALU_JUMP;
                    if (w_op[0]) begin
                        w_dec.regWriteEnable  = 1'b1;
                        w_dec.forceWriteToR31 = 1'b1;
                        w_dec.writeRegFromPC  = 1'b1;
                    end
                end
                6'b000100, 6'b000101: begin
                    w_dec.aluFunction = {5'b11110, w_op[0]};
                    w_readsRs         = 1'b1;
                    w_readsRt         = 1'b1;
                end
                6'b000110, 6'b000111: begin
                    w_dec.aluFunction = {5'b11111, w_op[0]};
                    w_readsRs         = 1'b1;
                end
                6'b001???: begin
                    w_dec.aluSrc         = 1'b1;
                    w_dec.regWriteEnable = 1'b1;
                    w_readsRs            = (w_op[2:0] != 3'b111);
                    case (w_op[2:0])
                        3'b000, 3'b001: w_dec.aluFunction = c_ALU_ADD;
                        3'b010:         w_dec.aluFunction = 6'b101010;
                        3'b011:         w_dec.aluFunction = 6'b101011;
                        3'b100:         w_dec.aluFunction = 6'b100100;
                        3'b101:         w_dec.aluFunction = 6'b100101;
                        3'b110:         w_dec.aluFunction = 6'b100110;
                        default:        w_dec.aluFunction = 6'b001111;
                    endcase
                end
                6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: begin
                    w_dec.aluSrc         = 1'b1;
                    w_dec.regWriteEnable = 1'b1;
                    w_dec.memoryRE       = 1'b1;
                    w_dec.memoryToReg    = 1'b1;
                    w_dec.aluFunction    = c_ALU_ADD;
                    w_dec.sizeOut        = (w_op[1:0] == 2'b11) ? 2'b10 : w_op[1:0];
                    w_dec.loadUnsigned   = Instruction[28];
                    w_readsRs            = 1'b1;
                end
                6'b101000, 6'b101001, 6'b101011: begin
                    w_dec.aluSrc      = 1'b1;
                    w_dec.memoryWE    = 1'b1;
                    w_dec.aluFunction = c_ALU_ADD;
                    w_dec.sizeOut     = (w_op[1:0] == 2'b11) ? 2'b10 : w_op[1:0];
                    w_readsRs         = 1'b1;
                    w_readsRt         = 1'b1;
                end
                default: w_dec.illegal = 1'b1;
            endcase
            if (!w_dec.illegal) begin
                w_dec.writeReg = w_dec.forceWriteToR31 ? 5'd31 :
                                 w_dec.regDst          ? w_rd  : w_rt;
            end
        end
    end

    assign w_flush   = BranchTaken | r_ex.jump;
    assign w_loadUse = (LOAD_USE_STALL != 0) && r_ex.memoryRE && (r_ex.writeReg != 5'd0) &&
                       ((w_readsRs && (w_rs == r_ex.writeReg)) ||
                        (w_readsRt && (w_rt == r_ex.writeReg)));
    assign w_mulDivStall = r_mulDivBusy && (w_isMulDiv || w_isHiLoRead);
    // A redirect always wins so the squash can never be held off by an interlock.
    assign Stall    = !w_flush && (w_loadUse || w_mulDivStall);
    assign w_bubble = Stall | w_flush;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_ex          <= c_NOOP;
            r_mulDivCount <= 4'd0;
            r_mulDivBusy  <= 1'b0;
        end else begin
            r_ex <= w_bubble ? c_NOOP : w_dec;
            if (!w_bubble && w_isMulDiv) begin
                r_mulDivCount <= c_MULDIV_LOAD;
                r_mulDivBusy  <= 1'b1;
            end else if (r_mulDivBusy) begin
                if (r_mulDivCount == 4'd0) begin
                    r_mulDivBusy <= 1'b0;
                end else begin
                    r_mulDivCount <= r_mulDivCount - 4'd1;
                end
            end
        end
    end

    assign ExRegDst          = r_ex.regDst;
    assign ExRegWriteEnable  = r_ex.regWriteEnable;
    assign ExALUSrc          = r_ex.aluSrc;
    assign ExMemoryRE        = r_ex.memoryRE;
    assign ExMemoryWE        = r_ex.memoryWE;
    assign ExMemoryToReg     = r_ex.memoryToReg;
    assign ExJump            = r_ex.jump;
    assign ExPCFromReg       = r_ex.pcFromReg;
    assign ExWriteRegFromPC  = r_ex.writeRegFromPC;
    assign ExForceWriteToR31 = r_ex.forceWriteToR31;
    assign ExALUFunction     = r_ex.aluFunction;
    assign ExSizeOut         = r_ex.sizeOut;
    assign ExLoadUnsigned    = r_ex.loadUnsigned;
    assign ExWriteReg        = r_ex.writeReg;
    assign IllegalInstr      = r_ex.illegal;
    assign MulDivBusy        = r_mulDivBusy;

endmodule
`default_nettype wire

// File: tb/tb_pipe_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pipe_control_unit                                         |
// | Description : Directed scenarios plus randomized run against a reference   |
// |               model, on a default instance and a 1-cycle/no-interlock one. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_pipe_control_unit;

    typedef struct packed {
        logic       regDst;
        logic       regWe;
        logic       aluSrc;
        logic       memRe;
        logic       memWe;
        logic       memToReg;
        logic       jump;
        logic       pcFromReg;
        logic       wrFromPc;
        logic       force31;
        logic [5:0] aluFn;
        logic [1:0] size;
        logic       loadUns;
        logic [4:0] writeReg;
        logic       illegal;
    } exw_t;

    typedef struct packed {
        exw_t w;
        logic rs;
        logic rt;
        logic mulDiv;
        logic hiLo;
    } dec_t;

    localparam exw_t NOOP_W = '{size: 2'b11, default: '0};
    localparam exw_t ILL_W  = '{size: 2'b11, illegal: 1'b1, default: '0};

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        valid;
    logic        branch;
    int          nCompared = 0;
    int          nMismatched = 0;

    always #5 clk = ~clk;

    logic       aStall, aIllegal, aRegDst, aRegWe, aAluSrc, aMemRe, aMemWe, aMemToReg;
    logic       aJump, aPcFromReg, aWrFromPc, aForce31, aLoadUns, aBusy;
    logic [5:0] aAluFn;
    logic [1:0] aSize;
    logic [4:0] aWriteReg;
    logic       bStall, bIllegal, bRegDst, bRegWe, bAluSrc, bMemRe, bMemWe, bMemToReg;
    logic       bJump, bPcFromReg, bWrFromPc, bForce31, bLoadUns, bBusy;
    logic [5:0] bAluFn;
    logic [1:0] bSize;
    logic [4:0] bWriteReg;
    exw_t       aEx, bEx;

    assign aEx = exw_t'({aRegDst, aRegWe, aAluSrc, aMemRe, aMemWe, aMemToReg, aJump, aPcFromReg,
                         aWrFromPc, aForce31, aAluFn, aSize, aLoadUns, aWriteReg, aIllegal});
    assign bEx = exw_t'({bRegDst, bRegWe, bAluSrc, bMemRe, bMemWe, bMemToReg, bJump, bPcFromReg,
                         bWrFromPc, bForce31, bAluFn, bSize, bLoadUns, bWriteReg, bIllegal});

    pipe_control_unit #(.MULDIV_CYCLES(4), .LOAD_USE_STALL(1)) dut (
        .Clock(clk), .Reset(rst), .Instruction(instr), .InstrValid(valid), .BranchTaken(branch),
        .Stall(aStall), .IllegalInstr(aIllegal), .ExRegDst(aRegDst), .ExRegWriteEnable(aRegWe),
        .ExALUSrc(aAluSrc), .ExMemoryRE(aMemRe), .ExMemoryWE(aMemWe), .ExMemoryToReg(aMemToReg),
        .ExJump(aJump), .ExPCFromReg(aPcFromReg), .ExWriteRegFromPC(aWrFromPc),
        .ExForceWriteToR31(aForce31), .ExALUFunction(aAluFn), .ExSizeOut(aSize),
        .ExLoadUnsigned(aLoadUns), .ExWriteReg(aWriteReg), .MulDivBusy(aBusy)
    );

    pipe_control_unit #(.MULDIV_CYCLES(1), .LOAD_USE_STALL(0)) dut2 (
        .Clock(clk), .Reset(rst), .Instruction(instr), .InstrValid(valid), .BranchTaken(branch),
        .Stall(bStall), .IllegalInstr(bIllegal), .ExRegDst(bRegDst), .ExRegWriteEnable(bRegWe),
        .ExALUSrc(bAluSrc), .ExMemoryRE(bMemRe), .ExMemoryWE(bMemWe), .ExMemoryToReg(bMemToReg),
        .ExJump(bJump), .ExPCFromReg(bPcFromReg), .ExWriteRegFromPC(bWrFromPc),
        .ExForceWriteToR31(bForce31), .ExALUFunction(bAluFn), .ExSizeOut(bSize),
        .ExLoadUnsigned(bLoadUns), .ExWriteReg(bWriteReg), .MulDivBusy(bBusy)
    );

    function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Reference decode written from the instruction-set rules, one mnemonic at a time.
    function automatic dec_t decode(input logic [31:0] ins, input logic v);
        dec_t       d;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rt;
        logic [4:0] rd;
        op = ins[31:26];
        fn = ins[5:0];
        rt = ins[20:16];
        rd = ins[15:11];
        d = '0;
        d.w.size = 2'b11;
        if (!v || ins == 32'd0) return d;
        if (op == 6'd0) begin
            if (fn == 6'o10 || fn == 6'o11) begin
                d.w.jump = 1; d.w.pcFromReg = 1; d.w.aluFn = 6'b111010; d.rs = 1; d.rt = 1;
                if (fn == 6'o11) begin d.w.regWe = 1; d.w.regDst = 1; d.w.wrFromPc = 1; end
            end else if (fn inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd16, 6'd17, 6'd18, 6'd19,
                                    6'd24, 6'd25, 6'd26, 6'd27, 6'd32, 6'd33, 6'd34, 6'd35,
                                    6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43}) begin
                d.w.regDst = 1; d.w.regWe = 1; d.w.aluFn = fn; d.rt = 1;
                d.rs     = !(fn inside {6'd0, 6'd2, 6'd3, 6'd16, 6'd18});
                d.mulDiv = (fn >= 6'd24) && (fn <= 6'd27);
                d.hiLo   = (fn == 6'd16) || (fn == 6'd18);
            end else begin
                d.w.illegal = 1;
            end
        end else begin
            case (op)
                6'o10, 6'o11: begin d.w.aluFn = 6'b100000; d.rs = 1; end
                6'o12:        begin d.w.aluFn = 6'b101010; d.rs = 1; end
                6'o13:        begin d.w.aluFn = 6'b101011; d.rs = 1; end
                6'o14:        begin d.w.aluFn = 6'b100100; d.rs = 1; end
                6'o15:        begin d.w.aluFn = 6'b100101; d.rs = 1; end
                6'o16:        begin d.w.aluFn = 6'b100110; d.rs = 1; end
                6'o17:        d.w.aluFn = 6'b001111;
                6'o40, 6'o44: d.w.size = 2'b00;
                6'o41, 6'o45: d.w.size = 2'b01;
                6'o43:        d.w.size = 2'b10;
                6'o50:        d.w.size = 2'b00;
                6'o51:        d.w.size = 2'b01;
                6'o53:        d.w.size = 2'b10;
                6'o02:        begin d.w.jump = 1; d.w.aluFn = 6'b111010; end
                6'o03: begin
                    d.w.jump = 1; d.w.aluFn = 6'b111010;
                    d.w.regWe = 1; d.w.force31 = 1; d.w.wrFromPc = 1;
                end
                6'o04: begin d.w.aluFn = 6'b111100; d.rs = 1; d.rt = 1; end
                6'o05: begin d.w.aluFn = 6'b111101; d.rs = 1; d.rt = 1; end
                6'o06: begin d.w.aluFn = 6'b111110; d.rs = 1; end
                6'o07: begin d.w.aluFn = 6'b111111; d.rs = 1; end
                6'o01: begin
                    if (rt == 5'd0)      begin d.w.aluFn = 6'b111000; d.rs = 1; end
                    else if (rt == 5'd1) begin d.w.aluFn = 6'b111001; d.rs = 1; end
                    else d.w.illegal = 1;
                end
                default: d.w.illegal = 1;
            endcase
            if (op >= 6'o10 && op <= 6'o17) begin
                d.w.aluSrc = 1; d.w.regWe = 1;
            end
            if (op inside {6'o40, 6'o41, 6'o43, 6'o44, 6'o45}) begin
                d.w.aluSrc = 1; d.w.regWe = 1; d.w.memRe = 1; d.w.memToReg = 1;
                d.w.aluFn = 6'b100000; d.w.loadUns = (op == 6'o44) || (op == 6'o45); d.rs = 1;
            end
            if (op inside {6'o50, 6'o51, 6'o53}) begin
                d.w.aluSrc = 1; d.w.memWe = 1; d.w.aluFn = 6'b100000; d.rs = 1; d.rt = 1;
            end
        end
        if (!d.w.illegal)
            d.w.writeReg = d.w.force31 ? 5'd31 : (d.w.regDst ? rd : rt);
        return d;
    endfunction

    function automatic logic [31:0] randInstr();
        logic [5:0] fnList [26] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd16, 6'd17, 6'd18,
                                    6'd19, 6'd24, 6'd25, 6'd26, 6'd27, 6'd32, 6'd33, 6'd34,
                                    6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43, 6'd8, 6'd9};
        logic [5:0] ldList [5] = '{6'o40, 6'o41, 6'o43, 6'o44, 6'o45};
        logic [5:0] stList [3] = '{6'o50, 6'o51, 6'o53};
        logic [5:0] brList [5] = '{6'o01, 6'o04, 6'o05, 6'o06, 6'o07};
        logic [5:0] mdList [6] = '{6'd16, 6'd18, 6'd24, 6'd25, 6'd26, 6'd27};
        logic [4:0] rs, rt, rd;
        logic [15:0] lo;
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        lo = 16'($urandom);
        case ($urandom_range(0, 11))
            0, 1, 2: return rType(rs, rt, rd, fnList[$urandom_range(0, 23)]);
            3:       return iType({3'b001, 3'($urandom)}, rs, rt, lo);
            4, 11:   return iType(ldList[$urandom_range(0, 4)], rs, rt, lo);
            5:       return iType(stList[$urandom_range(0, 2)], rs, rt, lo);
            6:       return iType(brList[$urandom_range(0, 4)], rs, rt, lo);
            7: begin
                if ($urandom_range(0, 1) == 0) return {5'b00001, 1'($urandom), 26'($urandom)};
                return rType(rs, rt, rd, fnList[$urandom_range(24, 25)]);
            end
            8:       return rType(rs, rt, rd, mdList[$urandom_range(0, 5)]);
            9: begin
                if ($urandom_range(0, 1) == 0) return {6'b111111, 26'($urandom)};
                return rType(rs, rt, rd, 6'b000001);
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic [31:0] ins, input logic v, input logic br);
        instr  = ins;
        valid  = v;
        branch = br;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nCompared++;
        if (aEx !== NOOP_W) begin
            nMismatched++; $display("FAIL reset_ex got=%h exp=%h", aEx, NOOP_W);
        end
        nCompared++;
        if (aBusy !== 1'b0) begin
            nMismatched++; $display("FAIL reset_busy got=%b exp=0", aBusy);
        end
        nCompared++;
        if (aStall !== 1'b0) begin
            nMismatched++; $display("FAIL reset_stall got=%b exp=0", aStall);
        end
    endtask

    task automatic test_load_use();
        drive(iType(6'b100011, 5'd9, 5'd8, 16'd0), 1'b1, 1'b0);
        tick();
        nCompared++;
        if (aMemRe !== 1'b1 || aWriteReg !== 5'd8 || aSize !== 2'b10) begin
            nMismatched++; $display("FAIL lw_ex memRe=%b wr=%0d size=%b exp 1/8/10", aMemRe, aWriteReg, aSize);
        end
        drive(rType(5'd8, 5'd11, 5'd10, 6'b100000), 1'b1, 1'b0);
        nCompared++;
        if (aStall !== 1'b1) begin
            nMismatched++; $display("FAIL loaduse_stall got=%b exp=1", aStall);
        end
        nCompared++;
        if (bStall !== 1'b0) begin
            nMismatched++; $display("FAIL nointerlock_stall got=%b exp=0", bStall);
        end
        tick();
        nCompared++;
        if (aEx !== NOOP_W) begin
            nMismatched++; $display("FAIL loaduse_bubble got=%h exp=%h", aEx, NOOP_W);
        end
        #1;
        nCompared++;
        if (aStall !== 1'b0) begin
            nMismatched++; $display("FAIL loaduse_one_cycle got=%b exp=0", aStall);
        end
        tick();
        nCompared++;
        if (aRegDst !== 1'b1 || aAluFn !== 6'b100000 || aWriteReg !== 5'd10) begin
            nMismatched++; $display("FAIL add_enters regDst=%b fn=%b wr=%0d exp 1/100000/10", aRegDst, aAluFn, aWriteReg);
        end
    endtask

    task automatic test_load_r0();
        drive(iType(6'b100011, 5'd9, 5'd0, 16'd4), 1'b1, 1'b0);
        tick();
        drive(rType(5'd0, 5'd11, 5'd10, 6'b100000), 1'b1, 1'b0);
        nCompared++;
        if (aStall !== 1'b0) begin
            nMismatched++; $display("FAIL load_r0_stall got=%b exp=0", aStall);
        end
        tick();
    endtask

    task automatic test_branch_priority();
        drive(iType(6'b100011, 5'd9, 5'd8, 16'd0), 1'b1, 1'b0);
        tick();
        drive(rType(5'd8, 5'd11, 5'd10, 6'b100000), 1'b1, 1'b1);
        nCompared++;
        if (aStall !== 1'b0) begin
            nMismatched++; $display("FAIL flush_over_stall got=%b exp=0", aStall);
        end
        tick();
        nCompared++;
        if (aEx !== NOOP_W) begin
            nMismatched++; $display("FAIL flush_bubble got=%h exp=%h", aEx, NOOP_W);
        end
        branch = 1'b0;
    endtask

    task automatic test_muldiv();
        int stallCycles = 0;
        int bBusyCycles = 0;
        drive(rType(5'd4, 5'd5, 5'd0, 6'b011000), 1'b1, 1'b0);
        tick();
        nCompared++;
        if (aBusy !== 1'b1 || bBusy !== 1'b1) begin
            nMismatched++; $display("FAIL mult_busy a=%b b=%b exp 1/1", aBusy, bBusy);
        end
        drive(rType(5'd0, 5'd0, 5'd2, 6'b010010), 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (!aStall) break;
            stallCycles++;
            bBusyCycles += int'(bBusy);
            tick();
            #1;
        end
        nCompared++;
        if (stallCycles != 4) begin
            nMismatched++; $display("FAIL mflo_stall_cycles got=%0d exp=4", stallCycles);
        end
        nCompared++;
        if (aBusy !== 1'b0) begin
            nMismatched++; $display("FAIL busy_after_stall got=%b exp=0", aBusy);
        end
        nCompared++;
        if (bBusyCycles != 1) begin
            nMismatched++; $display("FAIL busy_1cycle got=%0d exp=1", bBusyCycles);
        end
        tick();
        nCompared++;
        if (aAluFn !== 6'b010010 || aWriteReg !== 5'd2) begin
            nMismatched++; $display("FAIL mflo_enters fn=%b wr=%0d exp 010010/2", aAluFn, aWriteReg);
        end
    endtask

    task automatic test_jal();
        drive({6'b000011, 26'h40}, 1'b1, 1'b0);
        tick();
        nCompared++;
        if (aWriteReg !== 5'd31 || aWrFromPc !== 1'b1 || aJump !== 1'b1 || aRegWe !== 1'b1) begin
            nMismatched++; $display("FAIL jal_ex wr=%0d fromPc=%b jump=%b we=%b exp 31/1/1/1", aWriteReg, aWrFromPc, aJump, aRegWe);
        end
        drive(iType(6'b001000, 5'd0, 5'd3, 16'd5), 1'b1, 1'b0);
        tick();
        nCompared++;
        if (aEx !== NOOP_W) begin
            nMismatched++; $display("FAIL jal_squash got=%h exp=%h", aEx, NOOP_W);
        end
    endtask

    task automatic test_illegal();
        drive(32'hFC00_0000, 1'b1, 1'b0);
        tick();
        nCompared++;
        if (aEx !== ILL_W) begin
            nMismatched++; $display("FAIL illegal_ex got=%h exp=%h", aEx, ILL_W);
        end
        drive(32'd0, 1'b1, 1'b0);
        tick();
        nCompared++;
        if (aIllegal !== 1'b0) begin
            nMismatched++; $display("FAIL illegal_pulse got=%b exp=0", aIllegal);
        end
    endtask

    task automatic test_reset_mid_muldiv();
        drive(rType(5'd4, 5'd5, 5'd0, 6'b011010), 1'b1, 1'b0);
        tick();
        drive(32'd0, 1'b1, 1'b0);
        tick();
        nCompared++;
        if (aBusy !== 1'b1) begin
            nMismatched++; $display("FAIL div_busy got=%b exp=1", aBusy);
        end
        rst = 1'b1;
        drive(rType(5'd1, 5'd2, 5'd3, 6'b100000), 1'b1, 1'b0);
        tick();
        nCompared++;
        if (aBusy !== 1'b0 || aEx !== NOOP_W) begin
            nMismatched++; $display("FAIL reset_mid_div busy=%b ex=%h exp 0/%h", aBusy, aEx, NOOP_W);
        end
        rst = 1'b0;
        tick();
        nCompared++;
        if (aBusy !== 1'b0 || aWriteReg !== 5'd3) begin
            nMismatched++; $display("FAIL after_reset busy=%b wr=%0d exp 0/3", aBusy, aWriteReg);
        end
    endtask

    task automatic test_random();
        exw_t        mEx [2];
        int          busyLeft [2];
        int          cN [2];
        int          cLu [2];
        logic        expStall [2];
        logic        actStall, actBusy, flush, luse, mds, hold;
        dec_t        d;
        logic [31:0] ins;
        logic        v;
        cN  = '{4, 1};
        cLu = '{1, 0};
        rst = 1'b1;
        drive(32'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        mEx      = '{NOOP_W, NOOP_W};
        busyLeft = '{0, 0};
        hold     = 1'b0;
        ins      = 32'd0;
        v        = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!hold) begin
                ins = randInstr();
                v   = ($urandom_range(0, 9) != 0);
            end
            drive(ins, v, 1'($urandom_range(0, 7) == 0));
            d = decode(ins, v);
            for (int k = 0; k < 2; k++) begin
                flush = branch | mEx[k].jump;
                luse  = (cLu[k] != 0) && mEx[k].memRe && (mEx[k].writeReg != 5'd0) &&
                        ((d.rs && ins[25:21] == mEx[k].writeReg) ||
                         (d.rt && ins[20:16] == mEx[k].writeReg));
                mds   = (busyLeft[k] > 0) && (d.mulDiv || d.hiLo);
                expStall[k] = !flush && (luse || mds);
                actStall = (k == 0) ? aStall : bStall;
                actBusy  = (k == 0) ? aBusy : bBusy;
                nCompared++;
                if (actStall !== expStall[k]) begin
                    nMismatched++; $display("FAIL rand_stall dut%0d cyc=%0d got=%b exp=%b", k, cyc, actStall, expStall[k]);
                end
                nCompared++;
                if (actBusy !== (busyLeft[k] > 0)) begin
                    nMismatched++; $display("FAIL rand_busy dut%0d cyc=%0d got=%b exp=%b", k, cyc, actBusy, busyLeft[k] > 0);
                end
                if (expStall[k] || flush) begin
                    mEx[k] = NOOP_W;
                    if (busyLeft[k] > 0) busyLeft[k]--;
                end else begin
                    mEx[k] = d.w;
                    if (d.mulDiv) busyLeft[k] = cN[k];
                    else if (busyLeft[k] > 0) busyLeft[k]--;
                end
            end
            hold = expStall[0];
            tick();
            nCompared++;
            if (aEx !== mEx[0]) begin
                nMismatched++; $display("FAIL rand_ex dut0 cyc=%0d got=%h exp=%h", cyc, aEx, mEx[0]);
            end
            nCompared++;
            if (bEx !== mEx[1]) begin
                nMismatched++; $display("FAIL rand_ex dut1 cyc=%0d got=%h exp=%h", cyc, bEx, mEx[1]);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        instr  = 32'd0;
        valid  = 1'b0;
        branch = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_load_use();
        test_load_r0();
        test_branch_priority();
        test_muldiv();
        test_jal();
        test_illegal();
        test_reset_mid_muldiv();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
